// File: rtl/ras_unit_pkg.sv
// ----------------------------------------------------------------------------
// ras_unit_pkg
//   Shared branch-predictor definitions used by the return-address stack.
//   Holds the branch-kind encoding and the default word-aligned PC width.
// ----------------------------------------------------------------------------
package ras_unit_pkg;

  // Default width of a word-aligned PC (byte PC[31:2]).
  localparam int PC_W_DEF = 30;

  // Branch-kind encoding shared with the predictor.
  typedef enum logic [2:0] {
    NOT_JUMP      = 3'd0,
    DIRECT_JUMP   = 3'd1,
    JUMP          = 3'd2,
    CALL          = 3'd3,
    RET           = 3'd4,
    INDIRECT_JUMP = 3'd5,
    OTHER_JUMP    = 3'd6
  } br_kind_e;

  // True when a kind field encodes a call.
  function automatic logic is_call(input logic [2:0] kind);
    return kind == CALL;
  endfunction

  // True when a kind field encodes a return.
  function automatic logic is_ret(input logic [2:0] kind);
    return kind == RET;
  endfunction

endpackage

// File: rtl/ras_unit_lifo.sv
// ----------------------------------------------------------------------------
// ras_lifo
//   One circular return-address stack with a whole-state load port.
//   Pushing into a full stack silently overwrites the oldest entry; popping an
//   empty stack is ignored. Load takes priority over push/pop, and push over
//   pop. The next-state values are exported so another instance can be
//   reloaded with exactly what this one will hold after the current edge.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   push, push_data        push push_data this cycle
//   pop                    pop this cycle
//   load_en                replace the whole state with load_mem/ptr/cnt
//   load_mem/ptr/cnt       state to load
//   top                    mem[ptr-1] when cnt>0, else 0 (registered state only)
//   cnt                    current occupancy, 0..DEPTH
//   nxt_mem/ptr/cnt        state that will be registered at the next edge
// ----------------------------------------------------------------------------
module ras_lifo #(
  parameter int DEPTH = 8,
  parameter int W     = 30,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  input  logic                      load_en,
  input  logic [DEPTH-1:0][W-1:0]   load_mem,
  input  logic [PTR_W-1:0]          load_ptr,
  input  logic [CNT_W-1:0]          load_cnt,
  output logic [W-1:0]              top,
  output logic [CNT_W-1:0]          cnt,
  output logic [DEPTH-1:0][W-1:0]   nxt_mem,
  output logic [PTR_W-1:0]          nxt_ptr,
  output logic [CNT_W-1:0]          nxt_cnt
);

  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [PTR_W-1:0]        top_idx;

  // ptr names the next free slot, so the top lives one below it (wrapping).
  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = (cnt_q != '0) ? mem_q[top_idx] : '0;
  assign cnt     = cnt_q;

  always_comb begin
    nxt_mem = mem_q;
    nxt_ptr = ptr_q;
    nxt_cnt = cnt_q;
    if (load_en) begin
      nxt_mem = load_mem;
      nxt_ptr = load_ptr;
      nxt_cnt = load_cnt;
    end else if (push) begin
      nxt_mem[ptr_q] = push_data;
      nxt_ptr        = ptr_q + PTR_W'(1);
      // Occupancy saturates; the wrapped write has already replaced the oldest.
      nxt_cnt        = (cnt_q == CNT_W'(DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
    end else if (pop && (cnt_q != '0)) begin
      // Memory is left intact; only the pointer and count move.
      nxt_ptr = top_idx;
      nxt_cnt = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= nxt_mem;
      ptr_q <= nxt_ptr;
      cnt_q <= nxt_cnt;
    end
  end

endmodule

// File: rtl/ras_unit.sv
// ----------------------------------------------------------------------------
// ras_unit
//   Return-address stack for the branch predictor. A speculative stack follows
//   fetch-stage predictions and supplies RET targets; a committed stack follows
//   resolved execute-side updates. On recover the speculative stack is loaded
//   with the committed stack's next state, so a committed update arriving in
//   the same cycle is included.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   pdc_valid, pdc_kind, pdc_ret_pc fetch-stage prediction
//   pdc_top, pdc_empty              speculative top (0 when empty) / empty flag
//   update_en, update_kind,
//   update_ret_pc                   resolved update from execute
//   recover                         misprediction flush
//   cmt_top, cmt_count              committed top (0 when empty) / occupancy
// ----------------------------------------------------------------------------
module ras_unit
  import ras_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = PC_W_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pdc_valid,
  input  logic [2:0]        pdc_kind,
  input  logic [PC_W-1:0]   pdc_ret_pc,
  output logic [PC_W-1:0]   pdc_top,
  output logic              pdc_empty,
  input  logic              update_en,
  input  logic [2:0]        update_kind,
  input  logic [PC_W-1:0]   update_ret_pc,
  input  logic              recover,
  output logic [PC_W-1:0]   cmt_top,
  output logic [CNT_W-1:0]  cmt_count
);

  logic                       cmt_push;
  logic                       cmt_pop;
  logic                       spec_push;
  logic                       spec_pop;
  logic [DEPTH-1:0][PC_W-1:0] cmt_nxt_mem;
  logic [PTR_W-1:0]           cmt_nxt_ptr;
  logic [CNT_W-1:0]           cmt_nxt_cnt;
  logic [CNT_W-1:0]           spec_cnt;
  logic [DEPTH-1:0][PC_W-1:0] spec_nxt_mem_unused;
  logic [PTR_W-1:0]           spec_nxt_ptr_unused;
  logic [CNT_W-1:0]           spec_nxt_cnt_unused;

  // Kind decode. Only CALL and RET touch a stack.
  assign cmt_push  = update_en && is_call(update_kind);
  assign cmt_pop   = update_en && is_ret(update_kind);
  // The load port already wins over push/pop inside the stack; gating here
  // keeps the prediction strobes quiet during a flush.
  assign spec_push = !recover && pdc_valid && is_call(pdc_kind);
  assign spec_pop  = !recover && pdc_valid && is_ret(pdc_kind);

  ras_lifo #(
    .DEPTH (DEPTH),
    .W     (PC_W)
  ) u_cmt (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmt_push),
    .push_data (update_ret_pc),
    .pop       (cmt_pop),
    .load_en   (1'b0),
    .load_mem  ('0),
    .load_ptr  ('0),
    .load_cnt  ('0),
    .top       (cmt_top),
    .cnt       (cmt_count),
    .nxt_mem   (cmt_nxt_mem),
    .nxt_ptr   (cmt_nxt_ptr),
    .nxt_cnt   (cmt_nxt_cnt)
  );

  ras_lifo #(
    .DEPTH (DEPTH),
    .W     (PC_W)
  ) u_spec (
    .clk       (clk),
    .rstn      (rstn),
    .push      (spec_push),
    .push_data (pdc_ret_pc),
    .pop       (spec_pop),
    .load_en   (recover),
    .load_mem  (cmt_nxt_mem),
    .load_ptr  (cmt_nxt_ptr),
    .load_cnt  (cmt_nxt_cnt),
    .top       (pdc_top),
    .cnt       (spec_cnt),
    .nxt_mem   (spec_nxt_mem_unused),
    .nxt_ptr   (spec_nxt_ptr_unused),
    .nxt_cnt   (spec_nxt_cnt_unused)
  );

  assign pdc_empty = (spec_cnt == '0);

endmodule

// File: tb/tb_ras_unit.sv
module tb_ras_unit;

  localparam int DEPTH = 8;
  localparam int PC_W  = 30;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [2:0] K_NOT_JUMP = 3'd0;
  localparam logic [2:0] K_CALL     = 3'd3;
  localparam logic [2:0] K_RET      = 3'd4;

  logic              clk;
  logic              rstn;
  logic              pdc_valid;
  logic [2:0]        pdc_kind;
  logic [PC_W-1:0]   pdc_ret_pc;
  logic [PC_W-1:0]   pdc_top;
  logic              pdc_empty;
  logic              update_en;
  logic [2:0]        update_kind;
  logic [PC_W-1:0]   update_ret_pc;
  logic              recover;
  logic [PC_W-1:0]   cmt_top;
  logic [CNT_W-1:0]  cmt_count;

  int checks;
  int passed;

  ras_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .pdc_valid     (pdc_valid),
    .pdc_kind      (pdc_kind),
    .pdc_ret_pc    (pdc_ret_pc),
    .pdc_top       (pdc_top),
    .pdc_empty     (pdc_empty),
    .update_en     (update_en),
    .update_kind   (update_kind),
    .update_ret_pc (update_ret_pc),
    .recover       (recover),
    .cmt_top       (cmt_top),
    .cmt_count     (cmt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pdc_valid     = 1'b0;
    pdc_kind      = K_NOT_JUMP;
    pdc_ret_pc    = '0;
    update_en     = 1'b0;
    update_kind   = K_NOT_JUMP;
    update_ret_pc = '0;
    recover       = 1'b0;
  endtask

  task automatic pdc_op(input logic [2:0] kind, input logic [PC_W-1:0] pc);
    pdc_valid  = 1'b1;
    pdc_kind   = kind;
    pdc_ret_pc = pc;
  endtask

  task automatic test_reset();
    checks++; if (pdc_empty !== 1'b1) $display("FAIL reset_pdc_empty got %0d want 1", pdc_empty); else passed++;
    checks++; if (pdc_top !== '0) $display("FAIL reset_pdc_top got %0h want 0", pdc_top); else passed++;
    checks++; if (cmt_count !== '0) $display("FAIL reset_cmt_count got %0d want 0", cmt_count); else passed++;
    checks++; if (cmt_top !== '0) $display("FAIL reset_cmt_top got %0h want 0", cmt_top); else passed++;
    // Predicted RET on an empty stack is ignored.
    pdc_op(K_RET, '0);
    step();
    idle();
    checks++; if (pdc_empty !== 1'b1) $display("FAIL underflow_pdc_empty got %0d want 1", pdc_empty); else passed++;
    checks++; if (pdc_top !== '0) $display("FAIL underflow_pdc_top got %0h want 0", pdc_top); else passed++;
  endtask

  task automatic test_push_pop();
    pdc_op(K_CALL, 30'h100);
    step();
    checks++; if (pdc_top !== 30'h100) $display("FAIL pp_first_call got %0h want 100", pdc_top); else passed++;
    pdc_op(K_CALL, 30'h200);
    step();
    checks++; if (pdc_top !== 30'h200) $display("FAIL pp_top_200 got %0h want 200", pdc_top); else passed++;
    checks++; if (pdc_empty !== 1'b0) $display("FAIL pp_not_empty got %0d want 0", pdc_empty); else passed++;
    pdc_op(K_RET, '0);
    step();
    checks++; if (pdc_top !== 30'h100) $display("FAIL pp_pop_top_100 got %0h want 100", pdc_top); else passed++;
    pdc_op(K_RET, '0);
    step();
    idle();
    checks++; if (pdc_empty !== 1'b1) $display("FAIL pp_empty_after_pops got %0d want 1", pdc_empty); else passed++;
    checks++; if (pdc_top !== '0) $display("FAIL pp_top_after_pops got %0h want 0", pdc_top); else passed++;
    // Non-CALL/RET kinds are no-ops; committed stack untouched by predictions.
    pdc_op(3'd1, 30'h3FF);
    step();
    idle();
    checks++; if (pdc_empty !== 1'b1) $display("FAIL pp_direct_jump_noop got %0d want 1", pdc_empty); else passed++;
    checks++; if (cmt_count !== '0) $display("FAIL pp_cmt_untouched got %0d want 0", cmt_count); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      pdc_op(K_CALL, PC_W'(i));
      step();
    end
    idle();
    checks++; if (pdc_top !== 30'h9) $display("FAIL ovf_top got %0h want 9", pdc_top); else passed++;
    // Entry 0x1 was overwritten; the eight pops see 0x9 down to 0x2.
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (pdc_top !== PC_W'(9 - i)) $display("FAIL ovf_pop%0d got %0h want %0h", i, pdc_top, 9 - i);
      else passed++;
      pdc_op(K_RET, '0);
      step();
    end
    idle();
    checks++; if (pdc_empty !== 1'b1) $display("FAIL ovf_empty got %0d want 1", pdc_empty); else passed++;
    checks++; if (pdc_top !== '0) $display("FAIL ovf_top_empty got %0h want 0", pdc_top); else passed++;
  endtask

  task automatic test_recover();
    // Both stacks see CALL 0xA, 0xB in the same cycles.
    update_en = 1'b1; update_kind = K_CALL; update_ret_pc = 30'hA;
    pdc_op(K_CALL, 30'hA);
    step();
    update_ret_pc = 30'hB;
    pdc_op(K_CALL, 30'hB);
    step();
    update_en = 1'b0; update_kind = K_NOT_JUMP;
    pdc_op(K_CALL, 30'hC);
    step();
    pdc_op(K_CALL, 30'hD);
    step();
    idle();
    checks++; if (pdc_top !== 30'hD) $display("FAIL rec_spec_before got %0h want d", pdc_top); else passed++;
    checks++; if (cmt_top !== 30'hB) $display("FAIL rec_cmt_top got %0h want b", cmt_top); else passed++;
    checks++; if (cmt_count !== CNT_W'(2)) $display("FAIL rec_cmt_count got %0d want 2", cmt_count); else passed++;
    recover = 1'b1;
    step();
    idle();
    checks++; if (pdc_top !== 30'hB) $display("FAIL rec_spec_after got %0h want b", pdc_top); else passed++;
    // Restored occupancy is 2, not 4.
    pdc_op(K_RET, '0);
    step();
    checks++; if (pdc_top !== 30'hA) $display("FAIL rec_pop1 got %0h want a", pdc_top); else passed++;
    pdc_op(K_RET, '0);
    step();
    idle();
    checks++; if (pdc_empty !== 1'b1) $display("FAIL rec_pop2_empty got %0d want 1", pdc_empty); else passed++;
  endtask

  task automatic test_recover_same_cycle();
    recover = 1'b1;
    update_en = 1'b1; update_kind = K_CALL; update_ret_pc = 30'hE;
    pdc_op(K_CALL, 30'hF);
    step();
    idle();
    checks++; if (pdc_top !== 30'hE) $display("FAIL rsc_pdc_top got %0h want e", pdc_top); else passed++;
    checks++; if (cmt_top !== 30'hE) $display("FAIL rsc_cmt_top got %0h want e", cmt_top); else passed++;
    checks++; if (cmt_count !== CNT_W'(3)) $display("FAIL rsc_cmt_count got %0d want 3", cmt_count); else passed++;
    // 0xF must be absent: popping 0xE exposes 0xB.
    pdc_op(K_RET, '0);
    step();
    idle();
    checks++; if (pdc_top !== 30'hB) $display("FAIL rsc_no_f got %0h want b", pdc_top); else passed++;
    // Committed RET pops only the committed stack.
    update_en = 1'b1; update_kind = K_RET;
    step();
    idle();
    checks++; if (cmt_top !== 30'hB) $display("FAIL rsc_cmt_ret got %0h want b", cmt_top); else passed++;
    checks++; if (pdc_top !== 30'hB) $display("FAIL rsc_spec_indep got %0h want b", pdc_top); else passed++;
    // Push it back so the committed stack holds three entries again.
    update_en = 1'b1; update_kind = K_CALL; update_ret_pc = 30'hE;
    step();
    idle();
  endtask

  task automatic test_async_reset();
    checks++; if (cmt_count !== CNT_W'(3)) $display("FAIL ar_pre_count got %0d want 3", cmt_count); else passed++;
    // Leave an in-flight push pending while reset asserts between edges.
    pdc_op(K_CALL, 30'h55);
    update_en = 1'b1; update_kind = K_CALL; update_ret_pc = 30'h66;
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (pdc_top !== '0) $display("FAIL ar_pdc_top got %0h want 0", pdc_top); else passed++;
    checks++; if (pdc_empty !== 1'b1) $display("FAIL ar_pdc_empty got %0d want 1", pdc_empty); else passed++;
    checks++; if (cmt_top !== '0) $display("FAIL ar_cmt_top got %0h want 0", cmt_top); else passed++;
    checks++; if (cmt_count !== '0) $display("FAIL ar_cmt_count got %0d want 0", cmt_count); else passed++;
    step();
    idle();
    rstn = 1'b1;
    step();
    checks++; if (cmt_count !== '0) $display("FAIL ar_post_count got %0d want 0", cmt_count); else passed++;
    checks++; if (pdc_empty !== 1'b1) $display("FAIL ar_post_empty got %0d want 1", pdc_empty); else passed++;
    pdc_op(K_CALL, 30'h7);
    step();
    idle();
    checks++; if (pdc_top !== 30'h7) $display("FAIL ar_after_push got %0h want 7", pdc_top); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    idle();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
    step();
    test_reset();
    test_push_pop();
    test_overflow();
    test_recover();
    test_recover_same_cycle();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
